// File: rtl/volume_meter_screen_pkg.sv
// Shared colours, theme records, bar bands and screen geometry for the volume meter screen.
package volume_screen_pkg;

  localparam logic [15:0] C_BLACK   = 16'h0000;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_PURPLE  = 16'h8010;
  localparam logic [15:0] C_ORANGE  = 16'hFD20;
  localparam logic [15:0] C_BROWN   = 16'hA145;
  localparam logic [15:0] C_SKYBLUE = 16'h867D;

  typedef struct packed {
    logic [15:0] low;
    logic [15:0] mid;
    logic [15:0] high;
    logic [15:0] marker;
    logic [15:0] bg;
  } theme_t;

  typedef enum logic [1:0] {BAND_LOW = 2'd0, BAND_MID = 2'd1, BAND_HIGH = 2'd2} band_t;
  typedef enum logic {PK_HOLD = 1'b0, PK_FALL = 1'b1} peak_state_t;

  localparam logic [6:0] OUTER_X_LO = 7'd1;
  localparam logic [6:0] OUTER_X_HI = 7'd94;
  localparam logic [5:0] OUTER_Y_LO = 6'd1;
  localparam logic [5:0] OUTER_Y_HI = 6'd62;
  localparam logic [6:0] MID_X_LO   = 7'd3;
  localparam logic [6:0] MID_X_HI   = 7'd92;
  localparam logic [5:0] MID_Y_LO   = 6'd3;
  localparam logic [5:0] MID_Y_HI   = 6'd60;
  localparam logic [6:0] INNER_X_LO = 7'd5;
  localparam logic [6:0] INNER_X_HI = 7'd90;
  localparam logic [5:0] INNER_Y_LO = 6'd5;
  localparam logic [5:0] INNER_Y_HI = 6'd58;
  localparam logic [6:0] BAR_X_LO   = 7'd18;
  localparam logic [6:0] BAR_X_HI   = 7'd77;
  localparam int         BAR_BASE_ROW = 32'sd46;

  function automatic theme_t theme_lookup(input logic [1:0] sel);
    theme_t t;
    case (sel)
      2'b00:   t = '{low: C_GREEN,  mid: C_YELLOW,  high: C_RED,     marker: C_WHITE, bg: C_BLACK};
      2'b01:   t = '{low: C_PURPLE, mid: C_BLUE,    high: C_ORANGE,  marker: C_BLACK, bg: C_WHITE};
      2'b10:   t = '{low: C_YELLOW, mid: C_GREEN,   high: C_MAGENTA, marker: C_WHITE, bg: C_BLUE};
      2'b11:   t = '{low: C_BROWN,  mid: C_MAGENTA, high: C_BLUE,    marker: C_BLACK, bg: C_SKYBLUE};
      default: t = '{low: C_GREEN,  mid: C_YELLOW,  high: C_RED,     marker: C_WHITE, bg: C_BLACK};
    endcase
    return t;
  endfunction

  // One-pixel outline of the rectangle spanning the given corners.
  function automatic logic on_rect(input logic [6:0] x, input logic [5:0] y,
                                   input logic [6:0] x_lo, input logic [6:0] x_hi,
                                   input logic [5:0] y_lo, input logic [5:0] y_hi);
    return (((x == x_lo) || (x == x_hi)) && (y >= y_lo) && (y <= y_hi)) ||
           (((y == y_lo) || (y == y_hi)) && (x >= x_lo) && (x <= x_hi));
  endfunction

endpackage

// File: rtl/volume_meter_screen_if.sv
// Pixel query, control and volume bundle between the frame source and the volume meter screen.
interface volume_meter_screen_if #(
  parameter int VOL_W = 5
);
  logic             frame_tick;
  logic [6:0]       x;
  logic [5:0]       y;
  logic [1:0]       theme_sw;
  logic [5:0]       display_sw;
  logic [VOL_W-1:0] volume;
  logic [15:0]      oled_data;

  modport master (output frame_tick, x, y, theme_sw, display_sw, volume, input oled_data);
  modport slave  (input frame_tick, x, y, theme_sw, display_sw, volume, output oled_data);
endinterface

// File: rtl/volume_level_tracker.sv
// Per-frame level ballistics (instant attack, stepped release) and, with PEAK_MARKER_EN, the peak-hold FSM.
module volume_level_tracker
  import volume_screen_pkg::*;
#(
  parameter int VOL_W            = 5,
  parameter int VOL_MAX          = 15,
  parameter int DECAY_FRAMES     = 4,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int LVL_W            = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [VOL_W-1:0] volume,
  output logic [LVL_W-1:0] level
`ifdef PEAK_MARKER_EN
  ,
  output logic [LVL_W-1:0] peak
`endif
);

  localparam int DEC_W = $clog2(DECAY_FRAMES + 1);

  logic [LVL_W-1:0] vin_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic [DEC_W-1:0] decay_cnt_r;
  logic [DEC_W-1:0] decay_nxt_s;

  // Clamp the instantaneous volume to full scale.
  always_comb begin
    if (volume > VOL_W'(VOL_MAX)) begin
      vin_s = LVL_W'(VOL_MAX);
    end else begin
      vin_s = LVL_W'(volume);
    end
  end

  // Attack jumps straight to the input; release steps down once every DECAY_FRAMES ticks.
  always_comb begin
    level_nxt_s = level_r;
    decay_nxt_s = decay_cnt_r;
    if (frame_tick) begin
      if (vin_s >= level_r) begin
        level_nxt_s = vin_s;
        decay_nxt_s = {DEC_W{1'b0}};
      end else if (decay_cnt_r == DEC_W'(DECAY_FRAMES - 1)) begin
        level_nxt_s = level_r - LVL_W'(1'b1);
        decay_nxt_s = {DEC_W{1'b0}};
      end else begin
        decay_nxt_s = decay_cnt_r + DEC_W'(1'b1);
      end
    end else begin
      level_nxt_s = level_r;
      decay_nxt_s = decay_cnt_r;
    end
  end

  // Level and release counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r     <= {LVL_W{1'b0}};
      decay_cnt_r <= {DEC_W{1'b0}};
    end else begin
      level_r     <= level_nxt_s;
      decay_cnt_r <= decay_nxt_s;
    end
  end

  assign level = level_r;

`ifdef PEAK_MARKER_EN
  localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1);

  peak_state_t      state_r;
  peak_state_t      state_nxt_s;
  logic [LVL_W-1:0] peak_r;
  logic [LVL_W-1:0] peak_nxt_s;
  logic [LVL_W-1:0] peak_dec_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_nxt_s;

  // Peak follows the post-tick level upward, holds, then falls one step per tick back to it.
  always_comb begin
    state_nxt_s = state_r;
    peak_nxt_s  = peak_r;
    hold_nxt_s  = hold_cnt_r;
    peak_dec_s  = peak_r - LVL_W'(1'b1);
    if (frame_tick && (level_nxt_s >= peak_r)) begin
      peak_nxt_s  = level_nxt_s;
      hold_nxt_s  = {HOLD_W{1'b0}};
      state_nxt_s = PK_HOLD;
    end else if (frame_tick) begin
      case (state_r)
        PK_HOLD: begin
          if (hold_cnt_r == HOLD_W'(PEAK_HOLD_FRAMES - 1)) begin
            state_nxt_s = PK_FALL;
            hold_nxt_s  = {HOLD_W{1'b0}};
          end else begin
            hold_nxt_s  = hold_cnt_r + HOLD_W'(1'b1);
          end
        end
        PK_FALL: begin
          peak_nxt_s = peak_dec_s;
          if (peak_dec_s == level_nxt_s) begin
            state_nxt_s = PK_HOLD;
            hold_nxt_s  = {HOLD_W{1'b0}};
          end else begin
            state_nxt_s = PK_FALL;
          end
        end
        default: begin
          state_nxt_s = PK_HOLD;
          hold_nxt_s  = {HOLD_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Peak FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= PK_HOLD;
      peak_r     <= {LVL_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      peak_r     <= peak_nxt_s;
      hold_cnt_r <= hold_nxt_s;
    end
  end

  assign peak = peak_r;
`endif

endmodule

// File: rtl/volume_meter_screen.sv
// Stacked level-bar screen for the 96x64 OLED: maps a pixel query to a registered RGB565 colour.
// Build with PEAK_MARKER_EN defined to draw the peak-hold marker row.
module volume_meter_screen
  import volume_screen_pkg::*;
#(
  parameter int NUM_BARS         = 6,
  parameter int BAR_H            = 5,
  parameter int VOL_W            = 5,
  parameter int VOL_MAX          = 15,
  parameter int DECAY_FRAMES     = 4,
  parameter int PEAK_HOLD_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  volume_meter_screen_if.slave bus
);

  localparam int LVL_W = $clog2(VOL_MAX + 1);

  logic [LVL_W-1:0] level_s;
  theme_t           theme_s;
  logic             in_cols_s;
  logic             bar_lit_s;
  logic             bar_en_s;
  logic             marker_s;
  logic [15:0]      bar_col_s;
  logic [15:0]      pixel_s;
  logic [15:0]      oled_data_r;
  int               y_i_s;
  int               lvl_i_s;
`ifdef PEAK_MARKER_EN
  logic [LVL_W-1:0] peak_s;
  int               pk_i_s;
  int               mark_row_s;
`endif

  function automatic int thr(input int k);
    return (k * VOL_MAX) / NUM_BARS;
  endfunction

  function automatic int bar_top(input int k);
    return BAR_BASE_ROW - (k + 32'sd1) * BAR_H + 32'sd1;
  endfunction

  function automatic int bar_bot(input int k);
    return BAR_BASE_ROW - k * BAR_H;
  endfunction

  function automatic band_t band_of(input int k);
    if (k < NUM_BARS / 32'sd3) begin
      return BAND_LOW;
    end else if (k < (32'sd2 * NUM_BARS) / 32'sd3) begin
      return BAND_MID;
    end else begin
      return BAND_HIGH;
    end
  endfunction

  volume_level_tracker #(
    .VOL_W            (VOL_W),
    .VOL_MAX          (VOL_MAX),
    .DECAY_FRAMES     (DECAY_FRAMES),
    .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES),
    .LVL_W            (LVL_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (bus.frame_tick),
    .volume     (bus.volume),
    .level      (level_s)
`ifdef PEAK_MARKER_EN
    ,
    .peak       (peak_s)
`endif
  );

  // Resolve which bar the row falls in, whether it is lit, and its band colour/enable.
  always_comb begin
    theme_s   = theme_lookup(bus.theme_sw);
    y_i_s     = int'(bus.y);
    lvl_i_s   = int'(level_s);
    in_cols_s = (bus.x >= BAR_X_LO) && (bus.x <= BAR_X_HI);
    bar_lit_s = 1'b0;
    bar_en_s  = 1'b0;
    bar_col_s = theme_s.bg;
    for (int k = 0; k < NUM_BARS; k++) begin
      if ((y_i_s >= bar_top(k)) && (y_i_s <= bar_bot(k))) begin
        bar_lit_s = (lvl_i_s > thr(k));
        case (band_of(k))
          BAND_LOW:  begin bar_en_s = bus.display_sw[5]; bar_col_s = theme_s.low;  end
          BAND_MID:  begin bar_en_s = bus.display_sw[4]; bar_col_s = theme_s.mid;  end
          BAND_HIGH: begin bar_en_s = bus.display_sw[3]; bar_col_s = theme_s.high; end
          default:   begin bar_en_s = 1'b0;              bar_col_s = theme_s.bg;   end
        endcase
      end else begin
        bar_lit_s = bar_lit_s;
      end
    end
  end

  // Marker sits on the top row of the highest bar the peak exceeds, lit or not.
  always_comb begin
`ifdef PEAK_MARKER_EN
    pk_i_s     = int'(peak_s);
    mark_row_s = bar_top(0);
    for (int k = 0; k < NUM_BARS; k++) begin
      if (pk_i_s > thr(k)) begin
        mark_row_s = bar_top(k);
      end else begin
        mark_row_s = mark_row_s;
      end
    end
    marker_s = (peak_s != {LVL_W{1'b0}}) && in_cols_s && (y_i_s == mark_row_s);
`else
    marker_s = 1'b0;
`endif
  end

  // Priority: borders outer to inner, then marker, then enabled lit bar, then background.
  always_comb begin
    pixel_s = theme_s.bg;
    if (bus.display_sw[2] && on_rect(bus.x, bus.y, OUTER_X_LO, OUTER_X_HI, OUTER_Y_LO, OUTER_Y_HI)) begin
      pixel_s = theme_s.low;
    end else if (bus.display_sw[1] && on_rect(bus.x, bus.y, MID_X_LO, MID_X_HI, MID_Y_LO, MID_Y_HI)) begin
      pixel_s = theme_s.mid;
    end else if (bus.display_sw[0] && on_rect(bus.x, bus.y, INNER_X_LO, INNER_X_HI, INNER_Y_LO, INNER_Y_HI)) begin
      pixel_s = theme_s.high;
    end else if (marker_s) begin
      pixel_s = theme_s.marker;
    end else if (in_cols_s && bar_lit_s && bar_en_s) begin
      pixel_s = bar_col_s;
    end else begin
      pixel_s = theme_s.bg;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oled_data_r <= 16'h0000;
    end else begin
      oled_data_r <= pixel_s;
    end
  end

  assign bus.oled_data = oled_data_r;

endmodule
